// File: rtl/mult_div_if.sv
// Request/response bundle between the multicycle control unit and the
// iterative multiply/divide unit.
interface mult_div_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes)
// producing HI/LO, one bit per cycle over WIDTH cycles.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       reset,
   mult_div_if.slave  md
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {IDLE, MULT, DIV, FINISH, DZERO} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // Booth accumulator {upper W+1, multiplier W, guard}; the extra upper bit
   // keeps the running partial product exact when a is the most negative value.
   logic [2*WIDTH+1:0] acc_q, acc_d;
   logic [WIDTH:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic               busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic [WIDTH:0]     booth_upper;
   logic [WIDTH:0]     shifted, trial;
   logic [WIDTH-1:0]   abs_a, abs_b;

   always_comb begin
      // NOTE: every _d and temporary gets a default first so no latch is inferred.
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      div_zero_d  = 1'b0;
      hi_d        = hi_q;
      lo_d        = lo_q;
      booth_upper = acc_q[2*WIDTH+1:WIDTH+1];
      shifted     = {rem_q, quo_q[WIDTH-1]};
      trial       = shifted - {1'b0, dvs_q};
      abs_a       = md.a[WIDTH-1] ? -md.a : md.a;
      abs_b       = md.b[WIDTH-1] ? -md.b : md.b;

      case (state_q)
         IDLE: begin
            if (md.start) begin
               if (!md.op) begin
                  state_d = MULT;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  mcand_d = {md.a[WIDTH-1], md.a};
                  acc_d   = {{(WIDTH+1){1'b0}}, md.b, 1'b0};
               end else if (md.b == '0) begin
                  state_d = DZERO;
               end else begin
                  state_d   = DIV;
                  cnt_d     = '0;
                  busy_d    = 1'b1;
                  rem_d     = '0;
                  quo_d     = abs_a;
                  dvs_d     = abs_b;
                  neg_quo_d = md.a[WIDTH-1] ^ md.b[WIDTH-1];
                  neg_rem_d = md.a[WIDTH-1];
               end
            end
         end
         MULT: begin
            if (cnt_q == CW'(WIDTH)) begin
               state_d = FINISH;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               hi_d    = acc_q[2*WIDTH:WIDTH+1];
               lo_d    = acc_q[WIDTH:1];
            end else begin
               case (acc_q[1:0])
                  2'b01:   booth_upper = booth_upper + mcand_q;
                  2'b10:   booth_upper = booth_upper - mcand_q;
                  default: booth_upper = acc_q[2*WIDTH+1:WIDTH+1];
               endcase
               acc_d = $signed({booth_upper, acc_q[WIDTH:0]}) >>> 1;
               cnt_d = cnt_q + CW'(1);
            end
         end
         DIV: begin
            if (cnt_q == CW'(WIDTH)) begin
               state_d = FINISH;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               hi_d    = neg_rem_q ? -rem_q : rem_q;
               lo_d    = neg_quo_q ? -quo_q : quo_q;
            end else begin
               rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
               cnt_d = cnt_q + CW'(1);
            end
         end
         FINISH: state_d = IDLE;
         DZERO: begin
            state_d    = IDLE;
            div_zero_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         mcand_q    <= mcand_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign md.busy     = busy_q;
   assign md.done     = done_q;
   assign md.div_zero = div_zero_q;
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at start,
// popped and compared when done pulses.
module tb_mult_div_unit;
   localparam int W       = 32;
   localparam int TIMEOUT = 100;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];
   exp_t last;

   mult_div_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, p, q, r;
      exp_t   e;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!op) begin
         p    = sa * sb;
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else begin
         q    = sa / sb;
         r    = sa % sb;
         e.hi = r[31:0];
         e.lo = q[31:0];
      end
      return e;
   endfunction

   task automatic push_exp(input logic [W-1:0] hi, input logic [W-1:0] lo);
      exp_t e;
      e.hi = hi;
      e.lo = lo;
      sb_q.push_back(e);
   endtask

   // Returns just after the sampling edge; operands are then scrambled.
   task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = ~op; bus.a = $urandom; bus.b = $urandom;
   endtask

   task automatic wait_done(input string name, input int inject_at);
      int   cyc;
      int   busy_cyc;
      bit   seen;
      exp_t e;
      cyc = 0; busy_cyc = 0; seen = 1'b0;
      @(negedge clk);
      while (!seen && cyc <= TIMEOUT) begin
         if (bus.busy) busy_cyc++;
         if (bus.div_zero) begin
            checks++; failures++;
            $display("FAIL %s_no_div_zero div_zero=1 required 0 at cycle %0d", name, cyc);
         end
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            if (cyc == inject_at) begin
               bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'h0000_0064; bus.b = 32'h0000_0003;
            end
            if (cyc == inject_at + 1) bus.start = 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout no done within %0d cycles", name, TIMEOUT);
         return;
      end
      checks++;
      if (cyc !== W + 1) begin
         failures++;
         $display("FAIL %s_latency got %0d required %0d", name, cyc, W + 1);
      end
      checks++;
      if (busy_cyc !== W + 1) begin
         failures++;
         $display("FAIL %s_busy_cycles got %0d required %0d", name, busy_cyc, W + 1);
      end
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s_unexpected_done queue empty", name);
      end else begin
         e = sb_q.pop_front();
         last = e;
         checks++;
         if (bus.hi !== e.hi) begin
            failures++;
            $display("FAIL %s_hi got %h required %h", name, bus.hi, e.hi);
         end
         checks++;
         if (bus.lo !== e.lo) begin
            failures++;
            $display("FAIL %s_lo got %h required %h", name, bus.lo, e.lo);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL %s_done_pulse done=%b required 0 one cycle later", name, bus.done);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
         failures++;
         $display("FAIL reset_flags busy/done/dz=%b required 000", {bus.busy, bus.done, bus.div_zero});
      end
      checks++;
      if ({bus.hi, bus.lo} !== 64'h0) begin
         failures++;
         $display("FAIL reset_hilo got %h_%h required 0", bus.hi, bus.lo);
      end
      reset = 1'b0;
   endtask

   task automatic test_mult;
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB);
      start_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
      wait_done("mult_7_x_m3", -1);
      push_exp(32'h3FFF_FFFF, 32'h0000_0001);
      start_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      wait_done("mult_maxpos", -1);
      push_exp(32'h4000_0000, 32'h0000_0000);
      start_op(1'b0, 32'h8000_0000, 32'h8000_0000);
      wait_done("mult_minneg", -1);
   endtask

   task automatic test_div;
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD);
      start_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
      wait_done("div_m7_2", -1);
      push_exp(32'h0000_0001, 32'hFFFF_FFFD);
      start_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE);
      wait_done("div_7_m2", -1);
      push_exp(32'h0000_0000, 32'h8000_0000);
      start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_overflow", -1);
   endtask

   task automatic test_div_zero;
      exp_t prev;
      int   dones;
      prev = last;
      dones = 0;
      start_op(1'b1, 32'h0000_0005, 32'h0000_0000);
      @(negedge clk);
      if (bus.done) dones++;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL dz_busy_n got %b required 0", bus.busy);
      end
      @(negedge clk);
      if (bus.done) dones++;
      checks++;
      if (bus.div_zero !== 1'b1) begin
         failures++;
         $display("FAIL dz_pulse div_zero=%b required 1", bus.div_zero);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL dz_busy_n1 got %b required 0", bus.busy);
      end
      @(negedge clk);
      if (bus.done) dones++;
      checks++;
      if (bus.div_zero !== 1'b0) begin
         failures++;
         $display("FAIL dz_one_cycle div_zero=%b required 0", bus.div_zero);
      end
      repeat (5) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      checks++;
      if (dones !== 0) begin
         failures++;
         $display("FAIL dz_no_done got %0d done pulses required 0", dones);
      end
      checks++;
      if ({bus.hi, bus.lo} !== {prev.hi, prev.lo}) begin
         failures++;
         $display("FAIL dz_hilo_hold got %h_%h required %h_%h", bus.hi, bus.lo, prev.hi, prev.lo);
      end
   endtask

   task automatic test_reset_mid_op;
      int dones;
      dones = 0;
      start_op(1'b0, 32'h1234_5678, 32'h0BAD_F00D);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
         failures++;
         $display("FAIL abort_flags busy/done/dz=%b required 000", {bus.busy, bus.done, bus.div_zero});
      end
      checks++;
      if ({bus.hi, bus.lo} !== 64'h0) begin
         failures++;
         $display("FAIL abort_hilo got %h_%h required 0", bus.hi, bus.lo);
      end
      reset = 1'b0;
      last.hi = '0;
      last.lo = '0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done || bus.busy) dones++;
      end
      checks++;
      if (dones !== 0) begin
         failures++;
         $display("FAIL abort_quiet got %0d busy/done cycles required 0", dones);
      end
      sb_q.push_back(model(1'b0, 32'hFFFF_8001, 32'h0001_2345));
      start_op(1'b0, 32'hFFFF_8001, 32'h0001_2345);
      wait_done("after_abort", -1);
   endtask

   task automatic test_start_while_busy;
      int dones;
      dones = 0;
      sb_q.push_back(model(1'b0, 32'h0000_0123, 32'hFFFF_FF00));
      start_op(1'b0, 32'h0000_0123, 32'hFFFF_FF00);
      wait_done("busy_ignore", 5);
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      checks++;
      if (dones !== 0) begin
         failures++;
         $display("FAIL busy_ignore_extra_done got %0d required 0", dones);
      end
      checks++;
      if (sb_q.size() !== 0) begin
         failures++;
         $display("FAIL busy_ignore_queue got %0d pending required 0", sb_q.size());
      end
   endtask

   task automatic test_back_to_back;
      logic         op;
      logic [W-1:0] a, b;
      for (int i = 0; i < 10; i++) begin
         op = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = (i % 3 == 0) ? W'($urandom_range(1, 9)) : $urandom;
         if (i % 4 == 1) a = -a;
         if (op && b == '0) b = 32'h0000_0001;
         sb_q.push_back(model(op, a, b));
         start_op(op, a, b);
         wait_done("back_to_back", -1);
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      last.hi   = '0;
      last.lo   = '0;
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_reset_mid_op();
      test_start_while_busy();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative signed 32-bit multiply/divide responder, driven by the multicycle control unit's Mult/Div state.
- The control unit pulses start with an opcode and operands from regs A/B, then waits on done or div_zero.
- On completion the unit holds the HI/LO results. The HI/LO registers latch them when HI_writeControl/LO_writeControl are asserted.
- A divide by zero raises div_zero, which the control unit routes to its DivZero exception state.

Parameters:
- WIDTH, 32, operand width; iteration count for both multiply and divide.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  1  0 = mult (signed), 1 = div (signed); sampled with start.
- a  in  WIDTH  multiplicand / dividend; sampled with start.
- b  in  WIDTH  multiplier / divisor; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; hi/lo valid in this cycle.
- div_zero  out  1  one-cycle pulse; divide with b == 0.
- hi  out  WIDTH  mult: upper product word; div: remainder.
- lo  out  WIDTH  mult: lower product word; div: quotient.

Behaviour:
- Reset (clk edge with reset=1): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; iteration counter=0.
- Reset has priority over everything and aborts any operation in progress. No done or div_zero pulse follows an abort.
- States: IDLE, MULT, DIV, FINISH, DZERO.
- IDLE, start=1, op=0: latch a/b, go to MULT, counter=0, busy=1.
- IDLE, start=1, op=1, b!=0: latch a/b, go to DIV, counter=0, busy=1.
- IDLE, start=1, op=1, b==0: go to DZERO.
- MULT: radix-2 Booth.
  - Accumulator {P[2W:0]} is initialised from a, b.
  - One add/sub-and-arithmetic-shift per cycle, WIDTH cycles total.
  - After the last iteration go to FINISH.
- DIV: restoring division on magnitudes |a|, |b|, one quotient bit per cycle, WIDTH cycles.
  - Sign fix-up applied when entering FINISH.
  - Quotient is negated if sign(a)!=sign(b).
  - Remainder takes the sign of a (truncation toward zero, MIPS semantics).
- FINISH: hi/lo registered at the entry edge; done=1 for exactly this one cycle, busy=0; next state IDLE.
- DZERO: div_zero=1 for one cycle; hi/lo unchanged; busy=0; done is NOT asserted; next state IDLE.
- Latency: start sampled at edge N.
  - Iterations run on edges N+1..N+WIDTH.
  - hi/lo/done update at edge N+WIDTH+1.
  - busy=1 from edge N to edge N+WIDTH+1.
  - Divide by zero: div_zero at edge N+1; busy never rises.
- hi/lo hold their last result until the next FINISH or a reset. Intermediate iterations never disturb hi/lo.
- start while busy, or during the FINISH/DZERO cycle: ignored; no queueing.
- Operands are sampled only at start. Changes to a/b/op afterwards have no effect.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000 (wraps), hi=0, done normally, no div_zero.
- Multiply never overflows: the full 2*WIDTH product is always exact.
- div_zero and done are mutually exclusive and never both 1.

Test Plan:
- Mult 7 x -3: a=0x00000007, b=0xFFFFFFFD, op=0 -> done at start+33 edges, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- Mult max positive: a=b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001. Also 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
- Signed divide: -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. 7 / -2 -> lo=0xFFFFFFFD, hi=0x00000001. 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: a=5, b=0, op=1 -> div_zero=1 one cycle after start; done never pulses; hi/lo keep the previous result; busy stays 0.
- Reset mid-op: start mult, assert reset at iteration 10 -> next edge busy=0, hi=lo=0, state IDLE; no done pulse. A new start afterwards completes correctly.
- Start while busy: second start with different operands at iteration 5 -> ignored; exactly one done; result matches the first operands.
